// File: rtl/sys_ctrl_burst_if.sv
// Bus bundle for sys_ctrl_burst: receive stream, transmit handshake, register file and ALU.
// The controller uses the master view; the surrounding system uses the slave view.
interface sys_ctrl_burst_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RF_ADDR    = 4,
    parameter int unsigned FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    TX_BUSY;
    logic                    RF_WR_EN;
    logic                    RF_RD_EN;
    logic [RF_ADDR-1:0]      RF_ADDRESS;
    logic [DATA_WIDTH-1:0]   RF_WR_DATA;
    logic [DATA_WIDTH-1:0]   RF_RD_DATA;
    logic                    RF_RD_VLD;
    logic                    ALU_EN;
    logic [FUN_WIDTH-1:0]    ALU_FUN;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_VLD;
    logic                    CLK_GATE_EN;
    logic                    CLKDIV_EN;
    logic                    ERR_FLAG;

    modport master (
        input  RX_P_DATA, RX_D_VLD, TX_BUSY, RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD,
        output TX_P_DATA, TX_D_VLD, RF_WR_EN, RF_RD_EN, RF_ADDRESS, RF_WR_DATA,
               ALU_EN, ALU_FUN, CLK_GATE_EN, CLKDIV_EN, ERR_FLAG
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, TX_BUSY, RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD,
        input  TX_P_DATA, TX_D_VLD, RF_WR_EN, RF_RD_EN, RF_ADDRESS, RF_WR_DATA,
               ALU_EN, ALU_FUN, CLK_GATE_EN, CLKDIV_EN, ERR_FLAG
    );
endinterface

// File: rtl/sys_ctrl_burst.sv
// System controller: decodes byte commands from the receiver, drives the register file and ALU,
// and streams read / ALU results back through the transmitter, including wrapping burst reads.
module sys_ctrl_burst #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RF_ADDR    = 4,
    parameter int unsigned FUN_WIDTH  = 4
) (
    input logic              CLK,
    input logic              RST,
    sys_ctrl_burst_if.master bus
);

    localparam logic [DATA_WIDTH-1:0] CmdRfWr  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CmdRfRd  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CmdAluOp = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CmdAluNo = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] CmdBurst = DATA_WIDTH'(8'hEE);

    typedef enum logic [3:0] {
        StIdle, StGetAddr, StGetData, StGetOpa, StGetOpb, StGetFun, StGetCnt,
        StRdReq, StRdWait, StAluWait, StTxSend, StTxHold
    } state_e;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   cmd_q;
    logic [RF_ADDR-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0]   tx_lo_q;
    logic [DATA_WIDTH-1:0]   tx_hi_q;
    logic                    hi_pending_q;
    logic                    busy_seen_q;

    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic                    tx_vld_q;
    logic                    rf_wr_en_q;
    logic                    rf_rd_en_q;
    logic [RF_ADDR-1:0]      rf_addr_q;
    logic [DATA_WIDTH-1:0]   rf_wr_data_q;
    logic                    alu_en_q;
    logic [FUN_WIDTH-1:0]    alu_fun_q;
    logic                    clk_gate_en_q;
    logic                    clkdiv_en_q;
    logic                    err_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= StIdle;
            cmd_q         <= '0;
            addr_q        <= '0;
            cnt_q         <= '0;
            tx_lo_q       <= '0;
            tx_hi_q       <= '0;
            hi_pending_q  <= 1'b0;
            busy_seen_q   <= 1'b0;
            tx_data_q     <= '0;
            tx_vld_q      <= 1'b0;
            rf_wr_en_q    <= 1'b0;
            rf_rd_en_q    <= 1'b0;
            rf_addr_q     <= '0;
            rf_wr_data_q  <= '0;
            alu_en_q      <= 1'b0;
            alu_fun_q     <= '0;
            clk_gate_en_q <= 1'b0;
            clkdiv_en_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            clkdiv_en_q <= 1'b1;
            // Strobes default low so every assertion below is a single-cycle pulse.
            rf_wr_en_q  <= 1'b0;
            rf_rd_en_q  <= 1'b0;
            tx_vld_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.RX_D_VLD) begin
                        case (bus.RX_P_DATA)
                            CmdRfWr, CmdRfRd, CmdBurst: begin
                                err_q   <= 1'b0;
                                cmd_q   <= bus.RX_P_DATA;
                                state_q <= StGetAddr;
                            end
                            CmdAluOp: begin
                                err_q   <= 1'b0;
                                state_q <= StGetOpa;
                            end
                            CmdAluNo: begin
                                err_q   <= 1'b0;
                                state_q <= StGetFun;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                StGetAddr: begin
                    if (bus.RX_D_VLD) begin
                        addr_q <= bus.RX_P_DATA[RF_ADDR-1:0];
                        if (cmd_q == CmdRfWr) begin
                            state_q <= StGetData;
                        end else if (cmd_q == CmdRfRd) begin
                            // A single read is a burst of one.
                            cnt_q      <= DATA_WIDTH'(1);
                            rf_rd_en_q <= 1'b1;
                            rf_addr_q  <= bus.RX_P_DATA[RF_ADDR-1:0];
                            state_q    <= StRdReq;
                        end else begin
                            state_q <= StGetCnt;
                        end
                    end
                end
                StGetData: begin
                    if (bus.RX_D_VLD) begin
                        rf_wr_en_q   <= 1'b1;
                        rf_addr_q    <= addr_q;
                        rf_wr_data_q <= bus.RX_P_DATA;
                        state_q      <= StIdle;
                    end
                end
                StGetOpa: begin
                    if (bus.RX_D_VLD) begin
                        rf_wr_en_q   <= 1'b1;
                        rf_addr_q    <= '0;
                        rf_wr_data_q <= bus.RX_P_DATA;
                        state_q      <= StGetOpb;
                    end
                end
                StGetOpb: begin
                    if (bus.RX_D_VLD) begin
                        rf_wr_en_q   <= 1'b1;
                        rf_addr_q    <= RF_ADDR'(1);
                        rf_wr_data_q <= bus.RX_P_DATA;
                        state_q      <= StGetFun;
                    end
                end
                StGetFun: begin
                    if (bus.RX_D_VLD) begin
                        alu_fun_q     <= bus.RX_P_DATA[FUN_WIDTH-1:0];
                        alu_en_q      <= 1'b1;
                        clk_gate_en_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= StAluWait;
                    end
                end
                StGetCnt: begin
                    if (bus.RX_D_VLD) begin
                        if (bus.RX_P_DATA == '0) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q      <= bus.RX_P_DATA;
                            rf_rd_en_q <= 1'b1;
                            rf_addr_q  <= addr_q;
                            state_q    <= StRdReq;
                        end
                    end
                end
                StRdReq: state_q <= StRdWait;
                StRdWait: begin
                    if (bus.RF_RD_VLD) begin
                        tx_lo_q      <= bus.RF_RD_DATA;
                        hi_pending_q <= 1'b0;
                        state_q      <= StTxSend;
                    end
                end
                StAluWait: begin
                    if (bus.ALU_OUT_VLD) begin
                        tx_lo_q       <= bus.ALU_OUT[DATA_WIDTH-1:0];
                        tx_hi_q       <= bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                        hi_pending_q  <= 1'b1;
                        alu_en_q      <= 1'b0;
                        clk_gate_en_q <= 1'b0;
                        state_q       <= StTxSend;
                    end
                end
                StTxSend: begin
                    if (!bus.TX_BUSY) begin
                        tx_data_q   <= tx_lo_q;
                        tx_vld_q    <= 1'b1;
                        busy_seen_q <= 1'b0;
                        state_q     <= StTxHold;
                    end
                end
                StTxHold: begin
                    // The transmitter must accept (busy high) and finish (busy low) each byte.
                    if (!busy_seen_q) begin
                        busy_seen_q <= bus.TX_BUSY;
                    end else if (!bus.TX_BUSY) begin
                        if (hi_pending_q) begin
                            tx_lo_q      <= tx_hi_q;
                            hi_pending_q <= 1'b0;
                            state_q      <= StTxSend;
                        end else if (cnt_q > DATA_WIDTH'(1)) begin
                            cnt_q      <= cnt_q - DATA_WIDTH'(1);
                            addr_q     <= addr_q + RF_ADDR'(1);
                            rf_addr_q  <= addr_q + RF_ADDR'(1);
                            rf_rd_en_q <= 1'b1;
                            state_q    <= StRdReq;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.TX_P_DATA   = tx_data_q;
    assign bus.TX_D_VLD    = tx_vld_q;
    assign bus.RF_WR_EN    = rf_wr_en_q;
    assign bus.RF_RD_EN    = rf_rd_en_q;
    assign bus.RF_ADDRESS  = rf_addr_q;
    assign bus.RF_WR_DATA  = rf_wr_data_q;
    assign bus.ALU_EN      = alu_en_q;
    assign bus.ALU_FUN     = alu_fun_q;
    assign bus.CLK_GATE_EN = clk_gate_en_q;
    assign bus.CLKDIV_EN   = clkdiv_en_q;
    assign bus.ERR_FLAG    = err_q;

endmodule
